// File: rtl/i281_exec_pkg.sv
// i281_exec_pkg
//   Shared definitions for the i281 execution controller: the state
//   encoding seen on the controller's state output and the default widths
//   for the PC, step counter and executed-instruction counter.
package i281_exec_pkg;

  localparam int DEF_PC_W   = 6;
  localparam int DEF_STEP_W = 8;
  localparam int DEF_CYC_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } exec_state_t;

endpackage

// File: rtl/i281_rise_detect.sv
// i281_rise_detect
//   Registered rising-edge detector for a level button input. A held input
//   produces a single one-cycle rise indication.
// Ports:
//   clock : system clock
//   reset : synchronous, active-low reset (clears the history register)
//   din   : level input, already debounced and synchronised
//   rise  : high while din is high and was low at the previous edge
module i281_rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_p1;

  // stage p1: previous-cycle copy of the input
  always_ff @(posedge clock) begin
    if (!reset) din_p1 <= 1'b0;
    else        din_p1 <= din;
  end

  assign rise = din & ~din_p1;

endmodule

// File: rtl/i281_exec_ctrl.sv
// i281_exec_ctrl
//   Execution controller for the single-cycle i281 CPU. Produces the shared
//   run enable (PC, registers, flags, code and data memory) and supports
//   free-run, N-instruction single-step, PC breakpoint and automatic halt on
//   the self-jump end-of-program idiom.
// Ports:
//   clock, reset       : clock and synchronous active-low reset
//   start, step_req    : level requests; only their rising edges act
//   stop, clear        : level stop request / return-to-IDLE with counter clear
//   step_n             : instructions per step request (0 behaves as 1)
//   bp_en, bp_addr     : breakpoint enable and PC
//   current_pc,next_pc : observed PC register and PC update value
//   run                : high = one instruction commits at the next edge
//   state, halted      : controller state (0 IDLE,1 RUN,2 STEP,3 HALT), HALT flag
//   bp_hit             : sticky breakpoint-stop flag
//   cycle_count        : saturating count of executed instructions
module i281_exec_ctrl
  import i281_exec_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int STEP_W = DEF_STEP_W,
  parameter int CYC_W  = DEF_CYC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_n,
  input  logic              clear,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   current_pc,
  input  logic [PC_W-1:0]   next_pc,
  output logic              run,
  output logic [1:0]        state,
  output logic              halted,
  output logic              bp_hit,
  output logic [CYC_W-1:0]  cycle_count
);

  localparam logic [STEP_W-1:0] REM_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0]  CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_ONE;
  endfunction

  exec_state_t       state_q;
  exec_state_t       state_d;
  logic [STEP_W-1:0] remaining;
  logic              start_rise;
  logic              step_rise;
  logic              bp_set;
  logic              bp_clr;
  logic              ctr_clr;
  logic              rem_load;
  logic              rem_dec;

  i281_rise_detect u_start_rise (
    .clock (clock),
    .reset (reset),
    .din   (start),
    .rise  (start_rise)
  );

  i281_rise_detect u_step_rise (
    .clock (clock),
    .reset (reset),
    .din   (step_req),
    .rise  (step_rise)
  );

  // stage p0: next-state and side-effect decode from registered state
  always_comb begin
    state_d  = state_q;
    bp_set   = 1'b0;
    bp_clr   = 1'b0;
    ctr_clr  = 1'b0;
    rem_load = 1'b0;
    rem_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          ctr_clr = 1'b1;
        end else if (start_rise) begin
          state_d = ST_RUN;
          bp_clr  = 1'b1;
        end else if (step_rise) begin
          state_d  = ST_STEP;
          bp_clr   = 1'b1;
          rem_load = 1'b1;
        end
      end
      ST_RUN, ST_STEP: begin
        // The instruction in flight this cycle still commits (run is high),
        // so every exit below takes effect one instruction later.
        if (clear || stop) begin
          state_d = ST_IDLE;
        end else if (next_pc == current_pc) begin
          state_d = ST_HALT;
        end else if (bp_en && (next_pc == bp_addr)) begin
          state_d = ST_IDLE;
          bp_set  = 1'b1;
        end else if (state_q == ST_STEP) begin
          if (remaining == REM_ONE) state_d = ST_IDLE;
          else                      rem_dec = 1'b1;
        end
      end
      ST_HALT: begin
        if (clear) begin
          state_d = ST_IDLE;
          ctr_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // stage p1: registered state, outputs and counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      run         <= 1'b0;
      halted      <= 1'b0;
      bp_hit      <= 1'b0;
      remaining   <= '0;
      cycle_count <= '0;
    end else begin
      state_q <= state_d;
      run     <= (state_d == ST_RUN) || (state_d == ST_STEP);
      halted  <= (state_d == ST_HALT);

      if (ctr_clr)  cycle_count <= '0;
      else if (run) cycle_count <= sat_inc(cycle_count);

      if (bp_set)                bp_hit <= 1'b1;
      else if (bp_clr || ctr_clr) bp_hit <= 1'b0;

      if (ctr_clr)       remaining <= '0;
      else if (rem_load) remaining <= (step_n == '0) ? REM_ONE : step_n;
      else if (rem_dec)  remaining <= remaining - REM_ONE;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_i281_exec_ctrl.sv
module tb_i281_exec_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step_req = 1'b0;
  logic [7:0] step_n = 8'd0;
  logic       clear = 1'b0;
  logic       bp_en = 1'b0;
  logic [5:0] bp_addr = 6'd0;
  logic [5:0] pc = 6'd0;
  logic [5:0] next_pc;
  logic       run;
  logic [1:0] state;
  logic       halted;
  logic       bp_hit;
  logic [15:0] cycle_count;

  logic       run_s;
  logic [1:0] state_s;
  logic       halted_s;
  logic       bp_hit_s;
  logic [3:0] cycle_count_s;

  // PC datapath stand-in
  logic       self_loop = 1'b0;
  logic       pc_load = 1'b0;
  logic [5:0] pc_load_val = 6'd0;
  int         run_cycles = 0;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  assign next_pc = self_loop ? pc : pc + 6'd1;

  always @(posedge clock) begin
    if (pc_load)  pc <= pc_load_val;
    else if (run) pc <= next_pc;
    if (run) run_cycles <= run_cycles + 1;
  end

  i281_exec_ctrl #(.PC_W(6), .STEP_W(8), .CYC_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .step_req(step_req), .step_n(step_n), .clear(clear), .bp_en(bp_en),
    .bp_addr(bp_addr), .current_pc(pc), .next_pc(next_pc), .run(run),
    .state(state), .halted(halted), .bp_hit(bp_hit), .cycle_count(cycle_count)
  );

  i281_exec_ctrl #(.PC_W(6), .STEP_W(8), .CYC_W(4)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .step_req(step_req), .step_n(step_n), .clear(clear), .bp_en(bp_en),
    .bp_addr(bp_addr), .current_pc(pc), .next_pc(next_pc), .run(run_s),
    .state(state_s), .halted(halted_s), .bp_hit(bp_hit_s), .cycle_count(cycle_count_s)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_step;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
  endtask

  task automatic load_pc(input logic [5:0] v);
    pc_load = 1'b1;
    pc_load_val = v;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic clear_all;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    for (int i = 0; i < bound && state != 2'd0; i++) tick();
    tests++;
    if (state !== 2'd0) begin
      fails++;
      $display("FAIL %s timeout: state=%0d required 0", name, state);
    end
  endtask

  task automatic test_reset;
    tick(); tick(); tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d required 0", state); end
    tests++; if (run !== 1'b0) begin fails++; $display("FAIL reset_run: got %0d required 0", run); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %0d required 0", halted); end
    tests++; if (bp_hit !== 1'b0) begin fails++; $display("FAIL reset_bp_hit: got %0d required 0", bp_hit); end
    tests++; if (cycle_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d required 0", cycle_count); end
    reset = 1'b1;
    tick();
    load_pc(6'd0);
    pulse_start();
    repeat (37) tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL midrun_state: got %0d required 1", state); end
    tests++; if (cycle_count !== 16'd37) begin fails++; $display("FAIL midrun_count: got %0d required 37", cycle_count); end
    reset = 1'b0;
    tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL midreset_state: got %0d required 0", state); end
    tests++; if (run !== 1'b0) begin fails++; $display("FAIL midreset_run: got %0d required 0", run); end
    tests++; if (cycle_count !== 16'd0) begin fails++; $display("FAIL midreset_count: got %0d required 0", cycle_count); end
    tests++; if (bp_hit !== 1'b0) begin fails++; $display("FAIL midreset_bp_hit: got %0d required 0", bp_hit); end
    reset = 1'b1;
    tick();
  endtask

  // Single-step of n instructions from PC p0; expected values come from
  // the step rule alone: max(n,1) instructions, PC advances by that much.
  task automatic do_step(input string name, input int n, input int p0);
    int nexp;
    int r0;
    nexp = (n == 0) ? 1 : n;
    clear_all();
    load_pc(6'(p0));
    step_n = 8'(n);
    r0 = run_cycles;
    pulse_step();
    wait_idle(name, 400);
    tests++; if (run_cycles - r0 != nexp) begin fails++; $display("FAIL %s_run_cycles: got %0d required %0d", name, run_cycles - r0, nexp); end
    tests++; if (cycle_count !== 16'(nexp)) begin fails++; $display("FAIL %s_count: got %0d required %0d", name, cycle_count, nexp); end
    tests++; if (pc !== 6'((p0 + nexp) % 64)) begin fails++; $display("FAIL %s_pc: got %0d required %0d", name, pc, (p0 + nexp) % 64); end
  endtask

  task automatic test_step;
    bp_en = 1'b0;
    do_step("step3", 3, 0);
    do_step("step0", 0, 0);
    do_step("step_rand", int'($urandom_range(1, 200)), int'($urandom_range(0, 63)));
  endtask

  // Free-run from p0 with breakpoint k instructions ahead.
  task automatic do_bp(input string name, input int p0, input int k);
    int bp;
    bp = (p0 + k) % 64;
    clear_all();
    load_pc(6'(p0));
    bp_en = 1'b1;
    bp_addr = 6'(bp);
    pulse_start();
    wait_idle(name, 200);
    tests++; if (pc !== 6'(bp)) begin fails++; $display("FAIL %s_pc: got %0d required %0d", name, pc, bp); end
    tests++; if (bp_hit !== 1'b1) begin fails++; $display("FAIL %s_bp_hit: got %0d required 1", name, bp_hit); end
    tests++; if (cycle_count !== 16'(k)) begin fails++; $display("FAIL %s_count: got %0d required %0d", name, cycle_count, k); end
  endtask

  task automatic test_breakpoint;
    do_bp("bp5", 0, 5);
    pulse_start();
    tests++; if (bp_hit !== 1'b0) begin fails++; $display("FAIL bp_resume_clear: got %0d required 0", bp_hit); end
    tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL bp_no_retrap_state: got %0d required 1", state); end
    tests++; if (pc !== 6'd6) begin fails++; $display("FAIL bp_no_retrap_pc: got %0d required 6", pc); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL stop_state: got %0d required 0", state); end
    tests++; if (pc !== 6'd7) begin fails++; $display("FAIL stop_one_more: got %0d required 7", pc); end
    bp_en = 1'b0;
  endtask

  task automatic test_halt;
    clear_all();
    load_pc(6'd10);
    pulse_start();
    for (int i = 0; i < 10 && pc != 6'd12; i++) tick();
    self_loop = 1'b1;
    tick();
    tests++; if (state !== 2'd3) begin fails++; $display("FAIL halt_state: got %0d required 3", state); end
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag: got %0d required 1", halted); end
    tests++; if (run !== 1'b0) begin fails++; $display("FAIL halt_run: got %0d required 0", run); end
    tests++; if (cycle_count !== 16'd3) begin fails++; $display("FAIL halt_count: got %0d required 3", cycle_count); end
    pulse_start();
    pulse_step();
    repeat (3) tick();
    tests++; if (state !== 2'd3) begin fails++; $display("FAIL halt_ignore: got %0d required 3", state); end
    tests++; if (cycle_count !== 16'd3) begin fails++; $display("FAIL halt_ignore_count: got %0d required 3", cycle_count); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL halt_clear_state: got %0d required 0", state); end
    tests++; if (cycle_count !== 16'd0) begin fails++; $display("FAIL halt_clear_count: got %0d required 0", cycle_count); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_clear_flag: got %0d required 0", halted); end
    self_loop = 1'b0;
  endtask

  task automatic test_priority;
    // start and step_req rising together: start wins
    clear_all();
    load_pc(6'd0);
    step_n = 8'd2;
    start = 1'b1;
    step_req = 1'b1;
    tick();
    start = 1'b0;
    step_req = 1'b0;
    repeat (4) tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL both_rise: got %0d required 1", state); end
    // stop and breakpoint in the same cycle: stop wins
    clear_all();
    load_pc(6'd0);
    bp_en = 1'b1;
    bp_addr = 6'd5;
    pulse_start();
    for (int i = 0; i < 10 && pc != 6'd4; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL stop_vs_bp_state: got %0d required 0", state); end
    tests++; if (bp_hit !== 1'b0) begin fails++; $display("FAIL stop_vs_bp_hit: got %0d required 0", bp_hit); end
    bp_en = 1'b0;
    // start held high across a stop must not restart
    load_pc(6'd20);
    start = 1'b1;
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (5) tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL held_start: got %0d required 0", state); end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL restart: got %0d required 1", state); end
    start = 1'b0;
    clear_all();
  endtask

  task automatic test_saturation;
    clear_all();
    load_pc(6'd0);
    pulse_start();
    repeat (14) tick();
    tests++; if (cycle_count_s !== 4'd14) begin fails++; $display("FAIL sat_14: got %0d required 14", cycle_count_s); end
    tick();
    tests++; if (cycle_count_s !== 4'd15) begin fails++; $display("FAIL sat_15: got %0d required 15", cycle_count_s); end
    repeat (5) tick();
    tests++; if (cycle_count_s !== 4'd15) begin fails++; $display("FAIL sat_hold: got %0d required 15", cycle_count_s); end
    tests++; if (cycle_count !== 16'd20) begin fails++; $display("FAIL sat_wide: got %0d required 20", cycle_count); end
    clear_all();
  endtask

  task automatic test_random_ops;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        bp_en = 1'b0;
        do_step("rnd_step", int'($urandom_range(0, 25)), int'($urandom_range(0, 63)));
      end else begin
        do_bp("rnd_bp", int'($urandom_range(0, 63)), int'($urandom_range(1, 30)));
        bp_en = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_breakpoint();
    test_halt();
    test_priority();
    test_saturation();
    test_random_ops();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i281_exec_ctrl.md
Name: i281_exec_ctrl

Overview:
- Execution controller for the single-cycle i281 CPU. It generates the shared `run` enable that gates the PC, registers, flags, code memory and data memory.
- Supports free-run, N-instruction single-step, PC breakpoint, and automatic halt on the self-jump end-of-program idiom (JUMP -1).
- Sits between the board buttons/switches and the CPU top level. It observes `current_pc` and `next_pc` from the PC datapath.

Parameters:
- PC_W, 6, width of PC / code address
- STEP_W, 8, width of the step-count input and the remaining-steps counter
- CYC_W, 16, width of the executed-instruction counter

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clock
- start  in  1  run request, level, pre-debounced and synchronised; rising edge acts
- stop  in  1  stop request, level
- step_req  in  1  single-step request, level; rising edge acts
- step_n  in  STEP_W  instructions per step request; 0 is treated as 1
- clear  in  1  return to IDLE from any state; clears counters and bp_hit
- bp_en  in  1  breakpoint enable
- bp_addr  in  PC_W  breakpoint PC
- current_pc  in  PC_W  PC register value
- next_pc  in  PC_W  pc_update output
- run  out  1  CPU execute enable; high = one instruction commits at next edge
- state  out  2  0 IDLE, 1 RUN, 2 STEP, 3 HALT
- halted  out  1  state==HALT
- bp_hit  out  1  sticky breakpoint-stop flag
- cycle_count  out  CYC_W  instructions executed, saturating

Behaviour:
- Reset (reset==0 at edge), also mid-run: state=IDLE, run=0, bp_hit=0, cycle_count=0, remaining=0, edge-detect history regs=0.
- Moore outputs: run = (state==RUN || state==STEP); halted = (state==HALT). No combinational input-to-output paths.
- Rising edge of start/step_req = input high now, registered copy low. Holding a button high does not retrigger.
- IDLE:
  - start rise → RUN, bp_hit←0.
  - Otherwise step_req rise → STEP, remaining←max(step_n,1), bp_hit←0.
  - start wins if both rise in the same cycle.
- RUN/STEP checks each cycle, in priority order:
  1. clear → IDLE.
  2. stop → IDLE.
  3. next_pc==current_pc → HALT.
  4. bp_en && next_pc==bp_addr → IDLE, bp_hit←1.
  5. STEP with remaining==1 → IDLE.
  6. Otherwise stay; STEP decrements remaining.
- One-cycle latency: the instruction executing in the cycle a stop condition is detected still commits, because run was high. Consequences:
  - stop asserted costs exactly one more instruction.
  - A breakpoint leaves the CPU with current_pc==bp_addr and the bp instruction not yet executed.
  - Resuming (start or step) executes the bp instruction first. Its next_pc differs from bp_addr unless it self-loops, so there is no immediate re-trap.
- HALT: left only via clear (→ IDLE) or reset. start and step_req are ignored.
- clear in IDLE/HALT: cycle_count←0, bp_hit←0, remaining←0.
- cycle_count: +1 at every edge where run==1; saturates at all-ones (no wrap).
- PC compares are exact PC_W-bit equality. PC wrap 63→0 is handled by the PC datapath; no special case here.

Decomposition:
- Package i281_exec_pkg holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, STEP=2'd2, HALT=2'd3);
  - default widths PC_W/STEP_W/CYC_W.
- One sub-module, i281_rise_detect: 1-bit registered rising-edge detector with the same clock/active-low sync reset. Instantiated for start and step_req.
- The top-level CPU replaces its external run input with i281_exec_ctrl.run.

Test Plan:
- Reset mid-RUN (state=1, cycle_count=37): pull reset low one edge → state=0, run=0, cycle_count=0, bp_hit=0 at that edge.
- Step: IDLE, step_n=3, step_req pulse, PC sequence 0,1,2,3 → run high exactly 3 cycles, state returns 0, cycle_count=3. Repeat with step_n=0 → exactly 1 cycle.
- Breakpoint: bp_en=1, bp_addr=5, start pulse, linear PC from 0 → run high while executing PCs 0..4, then IDLE with current_pc=5, bp_hit=1, cycle_count=5. Second start → PC 5 executes, no re-trap, bp_hit=0.
- Self-loop halt: drive next_pc==current_pc=12 while in RUN → state=3, halted=1, run=0 next cycle. start/step_req ignored; clear → state=0, cycle_count=0.
- Priority/simultaneity:
  - start and step_req rise together in IDLE → RUN.
  - In RUN with stop=1 and next_pc==bp_addr simultaneously → IDLE, bp_hit=0 (stop wins).
  - start held high across a stop → no restart until it falls and rises again.
- Saturation: CYC_W=4, run 20 instructions → cycle_count holds 15.
